trace_buf_ctrl: RTL and testbench

- Controller for the trace RAM behind I2C logical addresses 0x30-0x3F.
- Writes 32-bit capture samples into an external simple dual-port RAM as a circular buffer.
- Serializes stored samples byte-by-byte onto the I2C bridge's read_data path, advancing on each bridge rd_pop pulse.
- Synchronizes the bridge's SCL-domain rd_pop and trace_rd_reset strobes into the system clock domain.

---
 rtl/trace_buf_ctrl.sv | 169 ++++++++++++++++
 tb/tb_trace_buf_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/trace_buf_ctrl.sv
// trace_buf_ctrl: circular trace buffer controller for the I2C trace window.
// Writes capture words into an external dual-port RAM and serializes stored
// words byte-by-byte (LSB first) onto the bridge read path.
module trace_buf_ctrl #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cap_valid,
  input  logic [DW-1:0] cap_data,
  input  logic          clear,
  input  logic          rd_pop_async,
  input  logic          trace_rd_reset_async,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_re,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rdata,
  output logic [7:0]    rd_byte,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underrun
);

  localparam int unsigned CW    = AW + 1;
  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [1:0] {ST_EMPTY, ST_FETCH, ST_LOAD, ST_HOLD} state_e;

  state_e        state_q, state_d;
  logic [2:0]    pop_sync_q, pop_sync_d;
  logic [2:0]    rrst_sync_q, rrst_sync_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    byte_sel_q, byte_sel_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          overflow_q, overflow_d;
  logic          underrun_q, underrun_d;

  logic pop_pulse, rrst_pulse, pop_eff, cap_ok, pop_done, is_full;

  assign pop_pulse  = pop_sync_q[1] & ~pop_sync_q[2];
  assign rrst_pulse = rrst_sync_q[1] & ~rrst_sync_q[2];
  assign is_full    = (count_q == CW'(DEPTH));
  // A read-restart beats a coincident pop; clear beats everything.
  assign pop_eff    = pop_pulse & ~rrst_pulse & ~clear;
  assign cap_ok     = cap_valid & ~is_full & ~clear;
  assign pop_done   = (state_q == ST_HOLD) & pop_eff & (byte_sel_q == 2'd3);

  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = is_full;
  assign overflow = overflow_q;
  assign underrun = underrun_q;

  // Datapath next-state: synchronizers, pointers, occupancy, byte select, flags.
  always_comb begin
    pop_sync_d  = {pop_sync_q[1:0], rd_pop_async};
    rrst_sync_d = {rrst_sync_q[1:0], trace_rd_reset_async};
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    byte_sel_d  = byte_sel_q;
    hold_d      = hold_q;
    overflow_d  = overflow_q;
    underrun_d  = underrun_q;
    if (state_q == ST_LOAD) begin
      hold_d = ram_rdata;
    end
    if (clear) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      byte_sel_d = '0;
      overflow_d = 1'b0;
      underrun_d = 1'b0;
    end else begin
      if (cap_ok) begin
        wptr_d = wptr_q + AW'(1);
      end
      if (cap_valid && is_full) begin
        overflow_d = 1'b1;
      end
      if (pop_eff && (state_q != ST_HOLD)) begin
        underrun_d = 1'b1;
      end
      if (rrst_pulse || (state_q == ST_LOAD)) begin
        byte_sel_d = '0;
      end else if (pop_eff && (state_q == ST_HOLD)) begin
        if (byte_sel_q == 2'd3) begin
          byte_sel_d = '0;
          rptr_d     = rptr_q + AW'(1);
        end else begin
          byte_sel_d = byte_sel_q + 2'd1;
        end
      end
      count_d = count_q + CW'(cap_ok) - CW'(pop_done);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_sync_q  <= '0;
      rrst_sync_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      byte_sel_q  <= '0;
      hold_q      <= '0;
      overflow_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      pop_sync_q  <= pop_sync_d;
      rrst_sync_q <= rrst_sync_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      byte_sel_q  <= byte_sel_d;
      hold_q      <= hold_d;
      overflow_q  <= overflow_d;
      underrun_q  <= underrun_d;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Read FSM next state; the post-pop decision uses occupancy after any same-cycle capture.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (count_q != '0) state_d = ST_FETCH;
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD:  state_d = ST_HOLD;
        ST_HOLD:  if (pop_done) state_d = (count_d != '0) ? ST_FETCH : ST_EMPTY;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Read FSM and write-port outputs.
  always_comb begin
    ram_we    = cap_ok;
    ram_waddr = wptr_q;
    ram_wdata = cap_data;
    ram_re    = (state_q == ST_FETCH);
    ram_raddr = rptr_q;
    rd_byte   = 8'h00;
    if (state_q == ST_HOLD) begin
      rd_byte = hold_q[{byte_sel_q, 3'b000} +: 8];
    end
  end

endmodule

// File: tb/tb_trace_buf_ctrl.sv
// Directed bench for trace_buf_ctrl with a byte scoreboard and a behavioral RAM.
module tb_trace_buf_ctrl;

  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cap_valid;
  logic [31:0]   cap_data;
  logic          clear;
  logic          rd_pop_async;
  logic          trace_rd_reset_async;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [31:0]   ram_rdata;
  logic [7:0]    rd_byte;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underrun;

  logic [31:0] mem [2**AW];
  logic [7:0]  sb [$];
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;

  trace_buf_ctrl #(.AW(AW), .DW(32)) dut (
    .clk(clk), .reset(reset), .cap_valid(cap_valid), .cap_data(cap_data),
    .clear(clear), .rd_pop_async(rd_pop_async),
    .trace_rd_reset_async(trace_rd_reset_async),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .rd_byte(rd_byte), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Simple dual-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) sb.push_back(w[8*i +: 8]);
  endtask

  // One-cycle capture; checks the combinational write port and records accepted data.
  task automatic capture(input logic [31:0] d, input logic exp_we, input logic [AW-1:0] exp_addr);
    cap_valid = 1'b1;
    cap_data  = d;
    #1;
    check("ram_we", 32'(ram_we), 32'(exp_we));
    if (exp_we) begin
      check("ram_waddr", 32'(ram_waddr), 32'(exp_addr));
      check("ram_wdata", ram_wdata, d);
      push_word(d);
    end
    @(negedge clk);
    cap_valid = 1'b0;
  endtask

  task automatic strobe_pop();
    rd_pop_async = 1'b1;
    cycles(3);
    rd_pop_async = 1'b0;
    cycles(8);
  endtask

  // Compare the presented byte with the scoreboard head, then pop it.
  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = 8'h00;
    if (sb.size() != 0) e = sb.pop_front();
    check(tag, 32'(rd_byte), 32'(e));
    strobe_pop();
  endtask

  initial begin
    logic [7:0] e;
    reset = 1'b1;
    cap_valid = 1'b0;
    cap_data = '0;
    clear = 1'b0;
    rd_pop_async = 1'b0;
    trace_rd_reset_async = 1'b0;
    cycles(2);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_rd_byte", 32'(rd_byte), 32'd0);
    check("rst_ram_re", 32'(ram_re), 32'd0);
    reset = 1'b0;
    cycles(2);

    // Single capture and four-byte readout.
    capture(32'h11223344, 1'b1, 2'd0);
    check("t1_count", 32'(count), 32'd1);
    cycles(6);
    check("t1_first_byte", 32'(rd_byte), 32'h44);
    for (int i = 0; i < 4; i++) pop_check("t1_pop");
    check("t1_count_end", 32'(count), 32'd0);
    check("t1_empty_end", 32'(empty), 32'd1);
    check("t1_rd_byte_end", 32'(rd_byte), 32'd0);

    // Fill to full, drop one, drain all with pointer wrap.
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    for (int i = 0; i < 4; i++) capture(32'hA0 + 32'(i), 1'b1, AW'(i));
    check("t2_full", 32'(full), 32'd1);
    check("t2_count4", 32'(count), 32'd4);
    capture(32'hA4, 1'b0, 2'd0);
    check("t2_overflow", 32'(overflow), 32'd1);
    check("t2_count_after_drop", 32'(count), 32'd4);
    cycles(6);
    for (int i = 0; i < 16; i++) pop_check("t2_pop");
    check("t2_count_end", 32'(count), 32'd0);
    check("t2_full_end", 32'(full), 32'd0);

    // Read restart re-presents the current entry from byte 0.
    capture(32'hDEADBEEF, 1'b1, 2'd0);
    cycles(6);
    pop_check("t3_pop");
    pop_check("t3_pop");
    check("t3_byte2", 32'(rd_byte), 32'hAD);
    trace_rd_reset_async = 1'b1;
    cycles(3);
    trace_rd_reset_async = 1'b0;
    cycles(8);
    sb.push_front(8'hBE);
    sb.push_front(8'hEF);
    check("t3_restart_byte", 32'(rd_byte), 32'hEF);
    check("t3_count", 32'(count), 32'd1);
    for (int i = 0; i < 4; i++) pop_check("t3_pop_after_restart");
    check("t3_count_end", 32'(count), 32'd0);

    // Pop on empty buffer, then clear flags.
    check("t4_underrun_pre", 32'(underrun), 32'd0);
    strobe_pop();
    check("t4_underrun", 32'(underrun), 32'd1);
    check("t4_count", 32'(count), 32'd0);
    check("t4_overflow_sticky", 32'(overflow), 32'd1);
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    check("t4_underrun_clr", 32'(underrun), 32'd0);
    check("t4_overflow_clr", 32'(overflow), 32'd0);
    check("t4_empty_clr", 32'(empty), 32'd1);

    // Entry-completing pop and capture in the same clock.
    capture(32'h55667788, 1'b1, 2'd0);
    cycles(6);
    for (int i = 0; i < 3; i++) pop_check("t5_pop");
    e = sb.pop_front();
    check("t5_last_byte", 32'(rd_byte), 32'(e));
    rd_pop_async = 1'b1;
    cycles(2);
    capture(32'h99AABBCC, 1'b1, 2'd1);
    rd_pop_async = 1'b0;
    check("t5_count_same", 32'(count), 32'd1);
    cycles(7);
    check("t5_new_entry", 32'(rd_byte), 32'hCC);
    for (int i = 0; i < 4; i++) pop_check("t5_pop_new");
    check("t5_count_end", 32'(count), 32'd0);
    check("t5_empty_end", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
